mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Shares a single instance of the team's signed (two's-complement) `array_mult` between two requesters. It arbitrates between them, registers the winner's operands, and captures the product into a held response register with a valid/ready handshake. The block sits between the datapath clients and the combinational multiplier, so the multiplier's long combinational path never reaches a client port.

## Interface
Parameters:
- `SIZE`, default 8: operand width in bits, passed straight to `array_mult`. Must be ≥ 3.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req0_valid` input 1: requester 0 has an operand pair.
- `req0_a`, `req0_b` input SIZE each: requester 0 signed operands.
- `req0_ready` output 1: requester 0 operands accepted this cycle (when `req0_valid` is also high).
- `req1_valid` input 1: requester 1 has an operand pair.
- `req1_a`, `req1_b` input SIZE each: requester 1 signed operands.
- `req1_ready` output 1: requester 1 operands accepted this cycle.
- `rsp_valid` output 1: `rsp_p` / `rsp_id` hold a completed product.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_p` output 2*SIZE: signed product a×b.
- `rsp_id` output 1: requester (0/1) that owns `rsp_p`.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **States.**
  - IDLE: accepting requests.
  - MULT: operands registered; the multiplier is settling.
  - RESP: product held until the consumer takes it.
- **Grant in IDLE.**
  - One requester valid: that requester is granted.
  - Both valid: the winner follows the Configuration section.
  - `reqN_ready` = (state == IDLE) & grantN. Both readies are 0 outside IDLE.
  - `ready` may depend combinationally on `valid`. Requesters must not make `valid` depend on `ready`.
- **Accept.** `reqN_valid & reqN_ready` at an edge does the following:
  - latch a, b into the operand register;
  - latch N into the id register;
  - update the last-grant pointer;
  - move to MULT.
- **Requester rule.** Once `valid` is raised, it and its operands must stay stable until accepted. The block does not check this.
- **MULT → RESP.** This happens unconditionally on the next edge. `array_mult(op_a, op_b)` is captured into `rsp_p`, and `rsp_valid` rises.
- **RESP.**
  - `rsp_valid` = 1; `rsp_p` and `rsp_id` are held stable.
  - On `rsp_valid & rsp_ready` at an edge → IDLE.
  - If `rsp_ready` stays low, the block stalls indefinitely in RESP, and both requesters see `ready` = 0.
- **Arithmetic.** Full-precision signed product; no truncation and no saturation.
  - Most negative squared, −2^(SIZE−1) × −2^(SIZE−1) = 2^(2·SIZE−2), fits without overflow.
  - Zero operands yield all-zero `rsp_p`.
- **Outputs are registered:** `rsp_valid`, `rsp_p`, `rsp_id`, `busy`. Only `reqN_ready` is combinational.

## Timing
- Reset (`rst_n` = 0 at an edge), from any state:
  - state = IDLE;
  - `rsp_valid` = 0, `rsp_p` = 0, `rsp_id` = 0, `busy` = 0;
  - operand register = 0;
  - last-grant pointer = 1, so requester 0 wins the first contention.
  - An operation in MULT or RESP is discarded; no response is ever produced for it.
- While `rst_n` = 0, both readies are 0.
- Latency: accept at edge E0 → `rsp_valid` high after edge E0+1 (2 edges from accept to visible response).
- Minimum turnaround: 3 cycles per operation. The response handshake occurs at edge E0+2 at the earliest, and IDLE is re-entered after that edge. New requests are not accepted during the response-handshake cycle.
- A request arriving while busy waits. It is considered in the first IDLE cycle.
- A requester dropping `valid` in IDLE before being granted: no effect and no state change.

## Configuration
- Macro `MULT_ARB_RR_EN`.
  - **Defined:** round-robin arbitration. On contention, grant the requester that was not granted last; the pointer updates on every accept.
  - **Undefined:** fixed priority. Requester 0 always wins contention. The pointer register is still present and reset, but it is ignored.
- A single uncontended requester is granted identically in both modes.

## Test plan
- **Single op, SIZE=8.** req0 a=3, b=−5 (8'hFB) → req0_ready at E0; `rsp_valid` after E0+1 with `rsp_p`=16'hFFF1, `rsp_id`=0. Completes on `rsp_ready`=1.
- **Corner products.** a=b=−128 → 16'h4000. a=127, b=−128 → 16'hC080. a=0, b=−1 → 16'h0000.
- **Contention.** Both requesters valid continuously, `rsp_ready`=1.
  - With `MULT_ARB_RR_EN`: `rsp_id` sequence 0,1,0,1.
  - Without it: 0,0,0,0.
- **Back-pressure.** Hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_p` stable, both readies 0. Release → IDLE next edge; a pending req1 is accepted in the following cycle.
- **Reset mid-operation.** Assert `rst_n`=0 for one edge while in MULT, and again in a separate run while in RESP → every output is 0 next cycle, and no response appears for the aborted op. The first contention after reset grants requester 0.
- **Throughput.** A single requester, always valid, with `rsp_ready`=1 → exactly one accept per 3 cycles.

Source files
------------

// File: rtl/mult_arbiter.sv
// Two-requester front end for a shared signed array multiplier: arbitrate, register operands, hold the product.
// Optional MULT_ARB_RR_EN selects round-robin arbitration; fixed priority (requester 0) otherwise.

module array_mult #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] p
);

    logic signed [2*SIZE-1:0] a_ext;
    logic signed [2*SIZE-1:0] acc;

    // Shift-add rows; the sign bit of b carries negative weight.
    always_comb begin
        a_ext = signed'({{SIZE{a[SIZE-1]}}, a});
        acc   = '0;
        for (int i = 0; i < SIZE - 1; i++) begin
            if (b[i]) begin
                acc = acc + (a_ext <<< i);
            end
        end
        if (b[SIZE-1]) begin
            acc = acc - (a_ext <<< (SIZE - 1));
        end
        p = acc;
    end

endmodule

module mult_arbiter #(
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [SIZE-1:0]     req0_a,
    input  logic [SIZE-1:0]     req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [SIZE-1:0]     req1_a,
    input  logic [SIZE-1:0]     req1_b,
    output logic                req1_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*SIZE-1:0]   rsp_p,
    output logic                rsp_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [SIZE-1:0]   op_a_p0;
    logic signed [SIZE-1:0]   op_b_p0;
    logic                     id_p0;
    logic                     last_grant;
    logic                     prio0;
    logic                     grant0;
    logic                     grant1;
    logic                     accept;
    logic [2*SIZE-1:0]        mult_p;

`ifdef MULT_ARB_RR_EN
    assign prio0 = last_grant;
`else
    // Pointer is still tracked, but fixed priority always favours requester 0.
    assign prio0 = last_grant | 1'b1;
`endif

    assign grant0     = req0_valid & (~req1_valid | prio0);
    assign grant1     = req1_valid & ~grant0;
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    array_mult #(.SIZE(SIZE)) u_mult (
        .a (op_a_p0),
        .b (op_b_p0),
        .p (mult_p)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MULT;
            MULT:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_p      <= '0;
            rsp_id     <= 1'b0;
            op_a_p0    <= '0;
            op_b_p0    <= '0;
            id_p0      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            // p0: winner's operands captured at accept
            if (accept) begin
                op_a_p0    <= grant1 ? signed'(req1_a) : signed'(req0_a);
                op_b_p0    <= grant1 ? signed'(req1_b) : signed'(req0_b);
                id_p0      <= grant1;
                last_grant <= grant1;
            end
            // p1: settled product captured into the held response
            if (state == MULT) begin
                rsp_p     <= mult_p;
                rsp_id    <= id_p0;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (SIZE=8): product table, contention, back-pressure, reset abort, throughput.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_p;
    logic        rsp_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[6];

    mult_arbiter #(.SIZE(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_p      (rsp_p),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        check("op_ready", {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("op_mult_state", {29'd0, busy, rsp_valid, req0_ready | req1_ready}, 32'd4);
        @(negedge clk);
        check("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("op_rsp_p", {16'd0, rsp_p}, {16'd0, exp});
        check("op_rsp_id", {31'd0, rsp_id}, {31'd0, id});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("op_back_idle", {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    task automatic contention(input logic [3:0] exp_ids);
        int   n = 0;
        logic [3:0] ids = '0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd2;   req0_b = 8'd3;
        req1_valid = 1'b1; req1_a = 8'hFC;  req1_b = 8'd5;
        rsp_ready  = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ids[n] = rsp_id;
                check("cont_p", {16'd0, rsp_p}, rsp_id ? 32'h0000FFEC : 32'h00000006);
                n++;
            end
        end
        check("cont_count", n, 4);
        check("cont_ids", {28'd0, ids}, {28'd0, exp_ids});
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd3,   8'hFB, 16'hFFF1};
        vecs[1] = '{1'b1, 8'h80,  8'h80, 16'h4000};
        vecs[2] = '{1'b0, 8'd127, 8'h80, 16'hC080};
        vecs[3] = '{1'b1, 8'd0,   8'hFF, 16'h0000};
        vecs[4] = '{1'b0, 8'hFF,  8'hFF, 16'h0001};
        vecs[5] = '{1'b1, 8'hF9,  8'd6,  16'hFFD6};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
        req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'd1;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_outputs", {13'd0, busy, rsp_valid, rsp_id, rsp_p}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        do_reset();
`ifdef MULT_ARB_RR_EN
        contention(4'b1010);
`else
        contention(4'b0000);
`endif

        // Back-pressure: response held for 10 cycles while req1 waits.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd5;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'hFE; req1_b = 8'd3;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            check("bp_p", {15'd0, rsp_valid, rsp_p}, 32'h00010019);
            check("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("bp_idle", {30'd0, busy, rsp_valid}, 32'd0);
        check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        check("bp_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("bp_rsp2", {14'd0, rsp_valid, rsp_id, rsp_p}, 32'h0003FFFA);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while in MULT.
        do_reset();
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd3;
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rmult_outputs", {13'd0, busy, rsp_valid, rsp_id, rsp_p}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rmult_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Reset while in RESP.
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'd4; req1_b = 8'd4;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        check("rresp_reached", {15'd0, rsp_valid, rsp_p}, 32'h00010010);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rresp_outputs", {13'd0, busy, rsp_valid, rsp_id, rsp_p}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
        req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'd1;
        #1;
        check("rresp_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("rresp_first_id", {30'd0, rsp_valid, rsp_id}, 32'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Throughput: single always-valid requester.
        do_reset();
        begin
            int accepts = 0;
            int last    = -3;
            int gap_bad = 0;
            req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd7;
            rsp_ready  = 1'b1;
            for (int c = 0; c < 30; c++) begin
                #1;
                if (req0_valid && req0_ready) begin
                    accepts++;
                    if (c - last != 3) gap_bad++;
                    last = c;
                end
                @(negedge clk);
            end
            check("thr_accepts", accepts, 10);
            check("thr_gaps", gap_bad, 0);
            req0_valid = 1'b0;
            rsp_ready  = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
